// File: rtl/channel_initiator_pkg.sv
// Shared definitions for the channel initiator: sequencer states, device
// command codes and the status-byte bit positions the sequencer inspects.
package channel_initiator_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SELECT,
      ST_ADDR_WAIT,
      ST_CMD,
      ST_CMD_END,
      ST_ISTAT,
      ST_ISTAT_END,
      ST_DATA,
      ST_DATA_END,
      ST_STOP,
      ST_STOP_END,
      ST_FSTAT,
      ST_FSTAT_END,
      ST_DONE
   } state_t;

   localparam logic [7:0] CMD_TEST_IO = 8'h00;
   localparam logic [7:0] CMD_WRITE   = 8'h01;
   localparam logic [7:0] CMD_READ    = 8'h02;
   localparam logic [7:0] CMD_NOP     = 8'h03;

   localparam int STAT_BUSY = 3;
   localparam int STAT_DE   = 4;
   localparam int STAT_CE   = 5;
   localparam int STAT_UC   = 6;

   // Initial status that closes the chain: device busy, or channel end with device end.
   function automatic logic chain_ends(input logic [7:0] st);
      return st[STAT_BUSY] || (st[STAT_CE] && st[STAT_DE]);
   endfunction

   function automatic logic is_data_cmd(input logic [7:0] c);
      return (c == CMD_WRITE) || (c == CMD_READ);
   endfunction

endpackage

// File: rtl/channel_initiator.sv
// Channel-side initiator: selects a device, sends a command, runs the optional
// byte-by-byte data phase over service tags and collects the ending status.
module channel_initiator
   import channel_initiator_pkg::*;
#(
   parameter int SEL_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] bus_out,
   input  logic [7:0] bus_in,
   output logic       operational_out,
   output logic       hold_out,
   output logic       select_out,
   output logic       address_out,
   output logic       command_out,
   output logic       service_out,
   output logic       suppress_out,
   input  logic       operational_in,
   input  logic       select_in,
   input  logic       address_in,
   input  logic       status_in,
   input  logic       service_in,
   input  logic       request_in,
   input  logic       start,
   input  logic [7:0] dev_addr,
   input  logic [7:0] cmd,
   input  logic [7:0] limit,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] status,
   output logic       no_device,
   output logic [7:0] xfer_count
);

   localparam int TW = $clog2(SEL_TIMEOUT + 2);

   state_t        state_reg;
   logic [7:0]    addr_reg;
   logic [7:0]    cmd_reg;
   logic [7:0]    limit_reg;
   logic [TW-1:0] timer_reg;

   logic is_write;
   logic count_hit;
   logic in_chain;
   logic unused_request;

   assign is_write       = (cmd_reg == CMD_WRITE);
   assign count_hit      = (xfer_count == limit_reg);
   assign in_chain       = !(state_reg inside {ST_IDLE, ST_SELECT, ST_DONE});
   assign suppress_out   = 1'b0;
   assign unused_request = request_in;

   // Write bytes are accepted in the same cycle the device asks for one.
   assign wr_ready = (state_reg == ST_DATA) && is_write && operational_in &&
                     service_in && !status_in && !count_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         addr_reg        <= '0;
         cmd_reg         <= '0;
         limit_reg       <= '0;
         timer_reg       <= '0;
         bus_out         <= '0;
         operational_out <= 1'b0;
         hold_out        <= 1'b0;
         select_out      <= 1'b0;
         address_out     <= 1'b0;
         command_out     <= 1'b0;
         service_out     <= 1'b0;
         rd_data         <= '0;
         rd_valid        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         status          <= '0;
         no_device       <= 1'b0;
         xfer_count      <= '0;
      end else begin
         operational_out <= 1'b1;
         done            <= 1'b0;
         rd_valid        <= 1'b0;
         if (!operational_in && in_chain) begin
            // Device dropped off the interface mid-chain.
            hold_out    <= 1'b0;
            select_out  <= 1'b0;
            address_out <= 1'b0;
            command_out <= 1'b0;
            service_out <= 1'b0;
            status      <= 8'hFF;
            state_reg   <= ST_DONE;
         end else begin
            case (state_reg)
               ST_IDLE: if (start) begin
                  addr_reg    <= dev_addr;
                  cmd_reg     <= cmd;
                  limit_reg   <= limit;
                  xfer_count  <= '0;
                  no_device   <= 1'b0;
                  bus_out     <= dev_addr;
                  address_out <= 1'b1;
                  select_out  <= 1'b1;
                  hold_out    <= 1'b1;
                  timer_reg   <= '0;
                  busy        <= 1'b1;
                  state_reg   <= ST_SELECT;
               end
               ST_SELECT: begin
                  if (operational_in) begin
                     address_out <= 1'b0;
                     timer_reg   <= '0;
                     state_reg   <= ST_ADDR_WAIT;
                  end else if (select_in || timer_reg == TW'(SEL_TIMEOUT)) begin
                     select_out  <= 1'b0;
                     hold_out    <= 1'b0;
                     address_out <= 1'b0;
                     no_device   <= 1'b1;
                     state_reg   <= ST_DONE;
                  end else begin
                     timer_reg <= timer_reg + TW'(1);
                  end
               end
               ST_ADDR_WAIT: if (address_in) begin
                  if (bus_in != addr_reg) no_device <= 1'b1;
                  bus_out     <= cmd_reg;
                  command_out <= 1'b1;
                  state_reg   <= ST_CMD;
               end
               ST_CMD: if (!address_in) begin
                  command_out <= 1'b0;
                  select_out  <= 1'b0;
                  hold_out    <= 1'b0;
                  state_reg   <= ST_ISTAT;
               end
               ST_ISTAT: if (status_in) begin
                  status      <= bus_in;
                  service_out <= 1'b1;
                  state_reg   <= ST_ISTAT_END;
               end
               ST_ISTAT_END: if (!status_in) begin
                  service_out <= 1'b0;
                  if (!chain_ends(status) && is_data_cmd(cmd_reg)) state_reg <= ST_DATA;
                  else                                            state_reg <= ST_DONE;
               end
               ST_DATA: begin
                  if (status_in) begin
                     state_reg <= ST_FSTAT;
                  end else if (service_in) begin
                     if (count_hit) begin
                        command_out <= 1'b1;
                        state_reg   <= ST_STOP;
                     end else if (is_write) begin
                        if (wr_valid) begin
                           bus_out     <= wr_data;
                           service_out <= 1'b1;
                           state_reg   <= ST_DATA_END;
                        end
                     end else begin
                        rd_data     <= bus_in;
                        rd_valid    <= 1'b1;
                        service_out <= 1'b1;
                        state_reg   <= ST_DATA_END;
                     end
                  end
               end
               ST_DATA_END: if (!service_in) begin
                  service_out <= 1'b0;
                  xfer_count  <= (xfer_count == 8'hFF) ? 8'hFF : xfer_count + 8'd1;
                  state_reg   <= ST_DATA;
               end
               ST_STOP: if (!service_in) begin
                  command_out <= 1'b0;
                  state_reg   <= ST_FSTAT;
               end
               ST_FSTAT: if (status_in) begin
                  status      <= bus_in;
                  service_out <= 1'b1;
                  state_reg   <= ST_FSTAT_END;
               end
               ST_FSTAT_END: if (!status_in) begin
                  service_out <= 1'b0;
                  state_reg   <= ST_DONE;
               end
               ST_DONE: begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= ST_IDLE;
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_channel_initiator.sv
// Randomised bench for channel_initiator: a behavioural device at address FFh
// answers the tag handshakes, and each operation is scored against expectations.
module tb_channel_initiator;
   import channel_initiator_pkg::*;

   localparam int TMO = 20;
   localparam logic [7:0] DEV_ADDR = 8'hFF;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] bus_out, bus_in = 8'h00;
   logic       operational_out, hold_out, select_out, address_out;
   logic       command_out, service_out, suppress_out;
   logic       operational_in = 1'b0, select_in = 1'b0, address_in = 1'b0;
   logic       status_in = 1'b0, service_in = 1'b0, request_in = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dev_addr = 8'h00, cmd = 8'h00, limit = 8'h00;
   logic [7:0] wr_data = 8'h00;
   logic       wr_valid = 1'b0, wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid, busy, done, no_device;
   logic [7:0] status, xfer_count;

   always #5 clk = ~clk;

   channel_initiator #(.SEL_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .bus_out(bus_out), .bus_in(bus_in),
      .operational_out(operational_out), .hold_out(hold_out), .select_out(select_out),
      .address_out(address_out), .command_out(command_out), .service_out(service_out),
      .suppress_out(suppress_out), .operational_in(operational_in), .select_in(select_in),
      .address_in(address_in), .status_in(status_in), .service_in(service_in),
      .request_in(request_in), .start(start), .dev_addr(dev_addr), .cmd(cmd), .limit(limit),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
      .rd_valid(rd_valid), .busy(busy), .done(done), .status(status),
      .no_device(no_device), .xfer_count(xfer_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Device personality for the current operation
   bit         dev_present, dev_loop;
   logic [7:0] dev_s0, dev_sf, got_cmd;
   int         dev_len, dphase, nbytes;
   logic [7:0] rd_src[$], wr_rx[$], host_q[$], obs_rd[$], op_data[$];
   int         done_cnt = 0;

   task data_offer();
      if (nbytes >= dev_len) begin
         status_in = 1'b1; bus_in = dev_sf; dphase = 9;
      end else begin
         service_in = 1'b1;
         bus_in = (got_cmd == CMD_READ) ? rd_src[nbytes] : 8'h00;
         dphase = 7;
      end
   endtask

   task device_step();
      if (reset) begin
         operational_in = 0; select_in = 0; address_in = 0; status_in = 0;
         service_in = 0; bus_in = 8'h00; wr_valid = 0; dphase = 0;
         return;
      end
      case (dphase)
         0: begin
            operational_in = 1'b0;
            if (select_out && hold_out && address_out && dev_present && bus_out == DEV_ADDR) begin
               operational_in = 1'b1; select_in = 1'b0; dphase = 1;
            end else begin
               select_in = dev_loop && select_out;
            end
         end
         1: if (!address_out) begin address_in = 1'b1; bus_in = DEV_ADDR; dphase = 2; end
         2: if (command_out) begin got_cmd = bus_out; address_in = 1'b0; dphase = 3; end
         3: if (!command_out) begin status_in = 1'b1; bus_in = dev_s0; dphase = 4; end
         4: if (service_out) begin status_in = 1'b0; dphase = 5; end
         5: if (!service_out) begin
            if (dev_s0[3] || (dev_s0[5] && dev_s0[4]) ||
                !(got_cmd == CMD_READ || got_cmd == CMD_WRITE)) begin
               operational_in = 1'b0; dphase = 0;
            end else begin
               nbytes = 0; data_offer();
            end
         end
         7: if (command_out) begin
            service_in = 1'b0; dphase = 8;
         end else if (service_out) begin
            if (got_cmd == CMD_WRITE) begin
               wr_rx.push_back(bus_out);
               if (host_q.size() > 0) void'(host_q.pop_front());
               wr_valid = 1'b0;
            end
            service_in = 1'b0; nbytes++; dphase = 10;
         end
         10: if (!service_out) data_offer();
         8: if (!command_out) begin status_in = 1'b1; bus_in = dev_sf; dphase = 9; end
         9: if (service_out) begin status_in = 1'b0; dphase = 11; end
         11: if (!service_out) begin operational_in = 1'b0; dphase = 0; end
         default: dphase = 0;
      endcase
   endtask

   task host_step();
      if (wr_valid && host_q.size() == 0) wr_valid = 1'b0;
      if (!reset && !wr_valid && host_q.size() > 0 && $urandom_range(0, 2) == 0) begin
         wr_valid = 1'b1; wr_data = host_q[0];
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rd_valid) obs_rd.push_back(rd_data);
         if (done) done_cnt++;
         device_step();
         host_step();
      end
   end

   task automatic run_op(input bit present, input bit loop, input logic [7:0] addr,
                         input logic [7:0] c, input logic [7:0] lim, input logic [7:0] s0,
                         input logic [7:0] sf, input int dlen);
      bit exp_nodev, exp_data;
      int exp_x, cycles;
      logic [7:0] exp_st;
      // Expected outcome straight from the protocol rules
      exp_nodev = !(present && addr == DEV_ADDR);
      exp_data  = !exp_nodev && !(s0[3] || (s0[5] && s0[4])) && (c == CMD_READ || c == CMD_WRITE);
      exp_x     = exp_data ? ((dlen < int'(lim)) ? dlen : int'(lim)) : 0;
      exp_st    = exp_data ? sf : s0;

      host_q.delete();
      @(negedge clk);
      dev_present = present; dev_loop = loop; dev_s0 = s0; dev_sf = sf; dev_len = dlen;
      rd_src = op_data;
      if (c == CMD_WRITE) for (int i = 0; i < int'(lim); i++) host_q.push_back(op_data[i]);
      obs_rd.delete(); wr_rx.delete(); done_cnt = 0;
      @(negedge clk);
      start = 1'b1; dev_addr = addr; cmd = c; limit = lim;
      @(negedge clk);
      start = 1'b0;
      cycles = 1;
      while (done_cnt == 0 && cycles < 3000) begin
         @(negedge clk);
         cycles++;
      end
      repeat (3) @(negedge clk);
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("no_device", 32'(no_device), 32'(exp_nodev));
      check_eq("xfer_count", 32'(xfer_count), 32'(exp_x));
      if (exp_nodev) check_eq("nodev_latency", 32'(cycles <= TMO + 4), 32'd1);
      else           check_eq("status", 32'(status), 32'(exp_st));
      if (exp_data && c == CMD_READ) begin
         check_eq("rd_count", 32'(obs_rd.size()), 32'(exp_x));
         for (int i = 0; i < obs_rd.size() && i < exp_x; i++)
            check_eq("rd_byte", 32'(obs_rd[i]), 32'(op_data[i]));
      end else begin
         check_eq("rd_none", 32'(obs_rd.size()), 32'd0);
      end
      if (exp_data && c == CMD_WRITE) begin
         check_eq("wr_count", 32'(wr_rx.size()), 32'(exp_x));
         for (int i = 0; i < wr_rx.size() && i < exp_x; i++)
            check_eq("wr_byte", 32'(wr_rx[i]), 32'(op_data[i]));
      end else begin
         check_eq("wr_none", 32'(wr_rx.size()), 32'd0);
      end
      $display("op addr=%h cmd=%h limit=%0d s0=%h status=%h xfer=%0d no_device=%0d cycles=%0d",
               addr, c, lim, s0, status, xfer_count, no_device, cycles);
   endtask

   task fill_data(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                  input logic [7:0] b3);
      op_data.delete();
      op_data.push_back(b0); op_data.push_back(b1); op_data.push_back(b2); op_data.push_back(b3);
      for (int i = 0; i < 4; i++) op_data.push_back(8'($urandom));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_eq("rst_tags", 32'({operational_out, hold_out, select_out, address_out,
                                command_out, service_out, suppress_out}), 32'd0);
      check_eq("rst_bus", 32'(bus_out), 32'd0);
      check_eq("rst_flags", 32'({busy, done, no_device, rd_valid, wr_ready}), 32'd0);
      check_eq("rst_status", 32'(status), 32'd0);
      check_eq("rst_xfer", 32'(xfer_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("op_out_up", 32'(operational_out), 32'd1);

      fill_data(8'h00, 8'h00, 8'h00, 8'h00);
      run_op(1, 1, DEV_ADDR, CMD_NOP, 8'd0, 8'h30, 8'h00, 8);
      fill_data(8'h01, 8'h02, 8'h03, 8'h04);
      run_op(1, 1, DEV_ADDR, CMD_READ, 8'd4, 8'h00, 8'h30, 8);
      fill_data(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      run_op(1, 1, DEV_ADDR, CMD_WRITE, 8'd3, 8'h00, 8'h30, 8);
      run_op(1, 1, DEV_ADDR, CMD_READ, 8'd4, 8'h08, 8'h30, 8);
      run_op(1, 1, 8'h42, CMD_READ, 8'd4, 8'h00, 8'h30, 8);
      run_op(0, 0, 8'h42, CMD_NOP, 8'd0, 8'h00, 8'h30, 8);
      run_op(1, 1, DEV_ADDR, CMD_READ, 8'd0, 8'h00, 8'h0C, 8);
      fill_data(8'h11, 8'h22, 8'h33, 8'h44);
      run_op(1, 1, DEV_ADDR, CMD_READ, 8'd6, 8'h00, 8'h0C, 2);

      for (int k = 0; k < 40; k++) begin
         bit pres;
         logic [7:0] a, c, s0;
         pres = ($urandom_range(0, 7) != 0);
         a    = ($urandom_range(0, 5) != 0) ? DEV_ADDR : 8'($urandom_range(0, 254));
         c    = 8'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            3:       s0 = 8'h08;
            4:       s0 = 8'h30;
            default: s0 = 8'h00;
         endcase
         fill_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         run_op(pres, 1, a, c, 8'($urandom_range(0, 6)), s0, 8'($urandom),
                $urandom_range(0, 8));
      end

      // Reset in the middle of a read data phase
      fill_data(8'h01, 8'h02, 8'h03, 8'h04);
      dev_present = 1; dev_loop = 1; dev_s0 = 8'h00; dev_sf = 8'h30; dev_len = 8;
      rd_src = op_data; obs_rd.delete(); host_q.delete();
      @(negedge clk);
      start = 1'b1; dev_addr = DEV_ADDR; cmd = CMD_READ; limit = 8'd4;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (obs_rd.size() == 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("reached_data", 32'(obs_rd.size() > 0), 32'd1);
      reset = 1'b1;
      done_cnt = 0;
      @(negedge clk);
      check_eq("mid_rst_tags", 32'({operational_out, hold_out, select_out, address_out,
                                    command_out, service_out, suppress_out}), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_bus", 32'(bus_out), 32'd0);
      check_eq("mid_rst_xfer", 32'(xfer_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("no_done_after_rst", 32'(done_cnt), 32'd0);
      check_eq("idle_after_rst", 32'({busy, operational_out}), 32'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/channel_initiator.md
CHANNEL_INITIATOR -- requirements
Module: channel_initiator

Interface
REQ-001 clk  in  1  rising-edge clock; reset  in  1  reset, synchronous, active-high.
REQ-002 Parameter SEL_TIMEOUT, default 255, cycles to wait for operational_in/select_in before declaring no-device.
REQ-003 bus_out  out  8  channel-to-device data/address/command byte; bus_in  in  8  device-to-channel byte.
REQ-004 Outbound tags (out, 1 each): operational_out, hold_out, select_out, address_out, command_out, service_out, suppress_out.
REQ-005 Inbound tags (in, 1 each): operational_in, select_in, address_in, status_in, service_in, request_in (request_in unused).
REQ-006 start  in  1  one-cycle pulse, begin operation; accepted only when busy=0.
REQ-007 dev_addr  in  8 / cmd  in  8 / limit  in  8  latched at start; limit = bytes to transfer.
REQ-008 wr_data  in  8 / wr_valid  in  1 / wr_ready  out  1  host write-byte stream, transfer on valid&ready.
REQ-009 rd_data  out  8 / rd_valid  out  1  read-byte stream, one-cycle pulse per byte, no backpressure.
REQ-010 busy  out  1; done  out  1 one-cycle pulse; status  out  8 final status byte; no_device  out  1; xfer_count  out  8.

Function
REQ-011 States: IDLE, SELECT, ADDR_WAIT, CMD, CMD_END, ISTAT, ISTAT_END, DATA, DATA_END, STOP, STOP_END, FSTAT, FSTAT_END, DONE.
REQ-012 operational_out=1 in every state except during reset; suppress_out=0 always.
REQ-013 IDLE: on start latch inputs, xfer_count<=0, no_device<=0, bus_out<=dev_addr, address_out<=1, select_out<=1, hold_out<=1, -> SELECT.
REQ-014 SELECT: operational_in=1 -> address_out<=0, reset timer, -> ADDR_WAIT; select_in=1 or timer=SEL_TIMEOUT -> drop select_out/hold_out/address_out, no_device<=1, -> DONE.
REQ-015 ADDR_WAIT: address_in=1 -> bus_out<=cmd, command_out<=1, -> CMD; bus_in≠dev_addr at that edge -> no_device<=1 still proceeds (logged only).
REQ-016 CMD: address_in=0 -> command_out<=0, drop select_out/hold_out, -> ISTAT.
REQ-017 ISTAT: status_in=1 -> status<=bus_in, service_out<=1, -> ISTAT_END.
REQ-018 ISTAT_END: status_in=0 -> service_out<=0; status bit3 (BUSY) or bits5:4 both set -> DONE; cmd 01h/02h -> DATA; else -> DONE.
REQ-019 DATA on service_in=1: xfer_count=limit -> command_out<=1 (STOP), -> STOP; write: wr_ready=1, on wr_valid drive bus_out<=wr_data, service_out<=1, -> DATA_END; read: rd_data<=bus_in, rd_valid pulse, service_out<=1, -> DATA_END.
REQ-020 Write with wr_valid=0: hold in DATA, service_out stays 0 (stall, no timeout).
REQ-021 DATA_END: service_in=0 -> service_out<=0, xfer_count+1, -> DATA; status_in=1 in DATA -> FSTAT path (device-ended early).
REQ-022 STOP: service_in=0 -> command_out<=0 -> FSTAT. limit=0 yields STOP at first service_in.
REQ-023 FSTAT: status_in=1 -> status<=bus_in, service_out<=1 -> FSTAT_END; FSTAT_END: status_in=0 -> service_out<=0 -> DONE.
REQ-024 DONE: done pulse one cycle, busy<=0, -> IDLE; busy=1 in all other non-IDLE states.
REQ-025 operational_in dropping outside IDLE/SELECT -> release all outbound tags except operational_out, status<=FFh, -> DONE.
REQ-026 xfer_count saturates at FFh; no wrap.

Reset
REQ-027 On reset all tags 0 except operational_out 0, bus_out 00h, status 00h, xfer_count 0, busy/done/no_device/rd_valid/wr_ready 0, state IDLE; reset mid-operation aborts without done.

Structure
REQ-028 Shared package holds state enumeration, command codes (TEST_IO 00h, WRITE 01h, READ 02h, NOP 03h) and status bit positions (BUSY 3, CE 5, DE 4, UC 6).
REQ-029 Single flat module; no sub-module.

Verification (against device model at address FFh)
REQ-030 NOP cmd 03h -> status 30h, done, xfer_count 0, no data tags.
REQ-031 READ 02h, limit 4 -> rd_data 01,02,03,04, final status 30h, xfer_count 4.
REQ-032 WRITE 01h, limit 3, wr_data AA,BB,CC -> device receives AA,BB,CC, status 30h.
REQ-033 Device busy -> initial status 08h, done, no data phase.
REQ-034 dev_addr 42h, no responder, select_in looped -> no_device=1, done within SEL_TIMEOUT+4 cycles.
REQ-035 Reset asserted in DATA -> all tags 0 next cycle, state IDLE, no done pulse.
